// File: rtl/onchip_memory_tester_pkg.sv
// Shared types and helpers for the on-chip RAM self-tester: FSM states,
// pattern LFSR taps and the LFSR step function.
package onchip_memory_tester_pkg;

  localparam int          DEFAULT_DEPTH = 51200;
  localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // 32-bit Galois step: shift right, fold the taps back in when bit 0 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/onchip_memory_tester_if.sv
// Avalon-MM bus between the tester (master) and the on-chip RAM slave port.
interface onchip_memory_tester_if #(
  parameter int ADDR_W = 16
);
  // chipselect is the request strobe; with no waitrequest every strobed cycle
  // is accepted on the edge that ends it, and readdata for a read is valid in
  // the following cycle.
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic              clken;
  logic [31:0]       readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/onchip_memory_tester_lfsr.sv
// Pattern generator: a single 32-bit Galois LFSR that is loaded with the seed
// at the start of each phase and stepped once per issued access.
module mem_pattern_lfsr
  import onchip_memory_tester_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        step,
  output logic [31:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       value <= '0;
    else if (load) value <= load_value;
    else if (step) value <= lfsr_next(value);
  end

endmodule

// File: rtl/onchip_memory_tester.sv
// Power-on RAM self-test master: fills a word range with an LFSR pattern,
// reads it back, and reports pass/fail, error count and first failing address.
module onchip_memory_tester
  import onchip_memory_tester_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic [31:0]           seed,
  onchip_memory_tester_if.master avm,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           error_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output state_t                state_dbg
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] base_q, addr_q, addr_n, addr_inc;
  logic [ADDR_W:0]   count_q, idx_q, idx_n;
  logic [31:0]       seed_q, lfsr_value, lfsr_seed;
  logic              lfsr_load, lfsr_step, capture;
  logic              cs_q, cs_n, we_q, we_n;
  logic              busy_n, done_n, pass_n;
  logic [15:0]       err_n;
  logic [ADDR_W-1:0] first_n;
  logic              cmp_valid, cmp_valid_n;
  logic [31:0]       exp_data;
  logic [ADDR_W-1:0] exp_addr;
  logic              last;

  assign last     = (idx_q == count_q - CNT_ONE);
  assign addr_inc = (addr_q == ADDR_W'(DEPTH-1)) ? '0 : addr_q + ADDR_W'(1);

  mem_pattern_lfsr u_lfsr (
    .clk        (clk),
    .rst        (reset),
    .load       (lfsr_load),
    .load_value (lfsr_seed),
    .step       (lfsr_step),
    .value      (lfsr_value)
  );

  always_comb begin
    state_n     = state;
    idx_n       = idx_q;
    addr_n      = addr_q;
    cs_n        = 1'b0;
    we_n        = 1'b0;
    busy_n      = busy;
    done_n      = 1'b0;
    pass_n      = pass;
    err_n       = error_count;
    first_n     = first_err_addr;
    capture     = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    lfsr_seed   = seed_q;
    cmp_valid_n = (state == ST_READ);

    // Readback compare runs off the pipelined expectation, independent of state.
    if (cmp_valid && (avm.readdata != exp_data)) begin
      if (error_count != 16'hFFFF) err_n = error_count + 16'd1;
      if (error_count == 16'd0)    first_n = exp_addr;
    end

    case (state)
      ST_IDLE: begin
        if (start) begin
          capture   = 1'b1;
          lfsr_seed = (seed == 32'h0) ? 32'h1 : seed;
          err_n     = '0;
          first_n   = '0;
          pass_n    = 1'b0;
          idx_n     = '0;
          if (word_count != '0) begin
            state_n   = ST_WRITE;
            addr_n    = base_addr;
            cs_n      = 1'b1;
            we_n      = 1'b1;
            busy_n    = 1'b1;
            lfsr_load = 1'b1;
          end else begin
            state_n = ST_DONE;
            done_n  = 1'b1;
            pass_n  = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        cs_n = 1'b1;
        if (last) begin
          // Turn straight around into reads: chipselect stays high.
          state_n   = ST_READ;
          addr_n    = base_q;
          idx_n     = '0;
          lfsr_load = 1'b1;
        end else begin
          we_n      = 1'b1;
          idx_n     = idx_q + CNT_ONE;
          addr_n    = addr_inc;
          lfsr_step = 1'b1;
        end
      end
      ST_READ: begin
        if (last) begin
          state_n = ST_DRAIN;
        end else begin
          cs_n      = 1'b1;
          idx_n     = idx_q + CNT_ONE;
          addr_n    = addr_inc;
          lfsr_step = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_n = ST_DONE;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        pass_n  = (err_n == 16'd0);
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q         <= '0;
      count_q        <= '0;
      seed_q         <= '0;
      idx_q          <= '0;
      addr_q         <= '0;
      cs_q           <= 1'b0;
      we_q           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      error_count    <= '0;
      first_err_addr <= '0;
      cmp_valid      <= 1'b0;
      exp_data       <= '0;
      exp_addr       <= '0;
    end else begin
      if (capture) begin
        base_q  <= base_addr;
        count_q <= word_count;
        seed_q  <= lfsr_seed;
      end
      idx_q          <= idx_n;
      addr_q         <= addr_n;
      cs_q           <= cs_n;
      we_q           <= we_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      error_count    <= err_n;
      first_err_addr <= first_n;
      cmp_valid      <= cmp_valid_n;
      exp_data       <= lfsr_value;
      exp_addr       <= addr_q;
    end
  end

  assign avm.address    = addr_q;
  assign avm.chipselect = cs_q;
  assign avm.write      = we_q;
  assign avm.byteenable = {4{cs_q}};
  assign avm.writedata  = lfsr_value;
  assign avm.clken      = 1'b1;
  assign state_dbg      = state;

endmodule

// File: tb/tb_onchip_memory_tester.sv
// Bench for onchip_memory_tester: ideal RAM model with an optional stuck-low
// bit, access scoreboard, vector table of runs and multi-cycle corner cases.
module tb_onchip_memory_tester;
  import onchip_memory_tester_pkg::*;

  localparam int DEPTH  = 51200;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic [31:0]       seed;
  logic              busy, done, pass;
  logic [15:0]       error_count;
  logic [ADDR_W-1:0] first_err_addr;
  state_t            state_dbg;

  onchip_memory_tester_if #(.ADDR_W(ADDR_W)) bus ();

  onchip_memory_tester #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
    .avm            (bus),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .error_count    (error_count),
    .first_err_addr (first_err_addr),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM model ----------------
  logic [31:0] mem [0:DEPTH-1];
  logic        fault_en = 1'b0;

  always @(posedge clk) begin
    if (bus.chipselect && bus.clken) begin
      if (bus.write)
        mem[bus.address] <= bus.writedata;
      else if (fault_en && bus.address == 16'h0010)
        bus.readdata <= mem[bus.address] & ~32'h80;
      else
        bus.readdata <= mem[bus.address];
    end
  end

  // ---------------- scoreboard ----------------
  logic [47:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_rd_q[$];

  function automatic logic [31:0] ref_step(input logic [31:0] v);
    logic [31:0] r;
    r = {1'b0, v[31:1]};
    if (v[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic push_expect(input logic [15:0] b, input logic [16:0] n, input logic [31:0] s);
    logic [31:0] v;
    logic [15:0] a;
    v = (s == 32'h0) ? 32'h1 : s;
    a = b;
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back({a, v});
      exp_rd_q.push_back(a);
      v = ref_step(v);
      a = (a == 16'(DEPTH-1)) ? 16'h0 : a + 16'h1;
    end
  endtask

  always @(negedge clk) begin
    logic [47:0] e;
    if (!reset && bus.chipselect) begin
      check("byteenable", 64'(bus.byteenable), 64'hF);
      if (bus.write) begin
        if (exp_q.size() == 0) check("unexpected_write", 64'(bus.address), 64'hDEAD);
        else begin
          e = exp_q.pop_front();
          check("write_addr", 64'(bus.address), 64'(e[47:32]));
          check("write_data", 64'(bus.writedata), 64'(e[31:0]));
        end
      end else begin
        if (exp_rd_q.size() == 0) check("unexpected_read", 64'(bus.address), 64'hBEEF);
        else check("read_addr", 64'(bus.address), 64'(exp_rd_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_test(input string name, input logic [15:0] b, input logic [16:0] n,
                          input logic [31:0] s, input logic f, input int poke,
                          input logic exp_pass, input logic [15:0] exp_errs,
                          input logic [15:0] exp_first);
    int cyc;
    int want;
    fault_en = f;
    push_expect(b, n, s);
    @(negedge clk);
    start = 1'b1; base_addr = b; word_count = n; seed = s;
    @(negedge clk);
    start = 1'b0; base_addr = 16'($urandom); word_count = 17'($urandom_range(1, 99)); seed = $urandom;
    cyc = 1;
    check({name, "_busy_c1"}, 64'(busy), 64'(n != 0));
    while (!done && cyc < 2 * int'(n) + 50) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke);
    end
    start = 1'b0;
    want = (n == 0) ? 1 : 2 * int'(n) + 2;
    check({name, "_done_seen"}, 64'(done), 64'h1);
    check({name, "_latency"}, 64'(cyc), 64'(want));
    check({name, "_pass"}, 64'(pass), 64'(exp_pass));
    check({name, "_errs"}, 64'(error_count), 64'(exp_errs));
    check({name, "_first"}, 64'(first_err_addr), 64'(exp_first));
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(done), 64'h0);
    check({name, "_pass_hold"}, 64'(pass), 64'(exp_pass));
    check({name, "_wr_left"}, 64'(exp_q.size()), 64'h0);
    check({name, "_rd_left"}, 64'(exp_rd_q.size()), 64'h0);
    fault_en = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [15:0] base;
    logic [16:0] count;
    logic [31:0] seed;
    logic        fault;
    logic        exp_pass;
    logic [15:0] exp_errs;
    logic [15:0] exp_first;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"clean",     16'd0,     17'd4,   32'h1,               1'b0, 1'b1, 16'd0, 16'h0};
    vecs[1] = '{"wrap",      16'd51198, 17'd4,   32'h1234_5678,       1'b0, 1'b1, 16'd0, 16'h0};
    vecs[2] = '{"fault",     16'd0,     17'd32,  32'h1,               1'b1, 1'b0, 16'd1, 16'h0010};
    vecs[3] = '{"zero_cnt",  16'd77,    17'd0,   32'h5,               1'b0, 1'b1, 16'd0, 16'h0};
    vecs[4] = '{"seed0",     16'd100,   17'd1,   32'h0,               1'b0, 1'b1, 16'd0, 16'h0};
    vecs[5] = '{"long_wrap", 16'd51100, 17'd300, $urandom | 32'h1000, 1'b0, 1'b1, 16'd0, 16'h0};

    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; seed = '0;
    repeat (2) @(negedge clk);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    check("rst_cs", 64'(bus.chipselect), 64'h0);
    check("rst_clken", 64'(bus.clken), 64'h1);
    check("rst_outs", {bus.address, bus.byteenable, bus.write, busy, done, pass, error_count, first_err_addr},
          64'h0);
    check("rst_wdata", 64'(bus.writedata), 64'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_test(vecs[i].name, vecs[i].base, vecs[i].count, vecs[i].seed, vecs[i].fault, 0,
               vecs[i].exp_pass, vecs[i].exp_errs, vecs[i].exp_first);

    // Reset during the write phase of a count=8 run.
    push_expect(16'd20, 17'd8, 32'hCAFE_0001);
    @(negedge clk);
    start = 1'b1; base_addr = 16'd20; word_count = 17'd8; seed = 32'hCAFE_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_state", 64'(state_dbg), 64'(ST_IDLE));
    check("midrst_cs", 64'(bus.chipselect), 64'h0);
    check("midrst_clken", 64'(bus.clken), 64'h1);
    check("midrst_outs", {bus.address, bus.byteenable, bus.write, busy, done, pass, error_count, first_err_addr},
          64'h0);
    check("midrst_wdata", 64'(bus.writedata), 64'h0);
    exp_q.delete();
    exp_rd_q.delete();
    @(negedge clk);
    reset = 1'b0;
    run_test("after_rst", 16'd20, 17'd8, 32'hCAFE_0001, 1'b0, 0, 1'b1, 16'd0, 16'h0);

    // A second start pulse in cycle 5 must not disturb the running test.
    run_test("start_busy", 16'd300, 17'd6, 32'h0BAD_F00D, 1'b0, 5, 1'b1, 16'd0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
